ps2_rx_frame: RTL

PS2_RX_FRAME -- requirements
Module: ps2_rx_frame

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_input_filter.sv | 57 +++++
 rtl/ps2_rx_frame.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// PS/2 receiver shared types and constants.
// Imported by the input filter and the frame decoder.
package ps2_pkg;

  localparam int DATA_BITS       = 8;
  localparam int FILTER_LEN_DEF  = 8;
  localparam int TIMEOUT_CYC_DEF = 20000;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronizes the raw PS/2 lines and debounces the clock line,
// producing a one-cycle strobe on each accepted clock falling edge.
module ps2_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_o,
  output logic data_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_s_q;
  logic [1:0]    dat_s_q;
  logic          clk_q, clk_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;

  // A new level must persist FILTER_LEN cycles before it replaces clk_q.
  always_comb begin
    clk_d  = clk_q;
    cnt_d  = '0;
    if (clk_s_q[1] != clk_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        clk_d = clk_s_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    fall_d = clk_q & ~clk_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_s_q <= 2'b11;
      dat_s_q <= 2'b11;
      clk_q   <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      clk_s_q <= {clk_s_q[0], ps2_clk_i};
      dat_s_q <= {dat_s_q[0], ps2_data_i};
      clk_q   <= clk_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign clk_o  = clk_q;
  assign data_o = dat_s_q[1];
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: start, 8 data LSB first,
// odd parity, stop; valid/ready byte output with error pulses.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overrun
);

  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int NW  = $clog2(DATA_BITS);

  logic clean_clk, clean_dat, fall;

  ps2_input_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk_i     (clk_100MHz),
    .rst_i     (reset),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .clk_o     (clean_clk),
    .data_o    (clean_dat),
    .fall_o    (fall)
  );

  state_e        state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          eper_q, eper_d;
  logic          efrm_q, efrm_d;
  logic          ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = valid_q;
    eper_d  = 1'b0;
    efrm_d  = 1'b0;
    ovr_d   = ovr_q;

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    if (state_q != IDLE && !fall) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        efrm_d  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!clean_dat) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            efrm_d = 1'b1;
          end
        end
        DATA: begin
          shift_d = {clean_dat, shift_q[7:1]};
          if (cnt_q == NW'(DATA_BITS - 1)) begin
            cnt_d   = '0;
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          par_d   = clean_dat;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!clean_dat) begin
            efrm_d = 1'b1;
          end else if (!(^{shift_q, par_q})) begin
            eper_d = 1'b1;
          end else if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      eper_q  <= 1'b0;
      efrm_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      eper_q  <= eper_d;
      efrm_q  <= efrm_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign err_parity = eper_q;
  assign err_frame  = efrm_q;
  assign overrun    = ovr_q;

  logic unused_clk;
  assign unused_clk = clean_clk;

endmodule
